d_cache: RTL and testbench
==========================

Name: d_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Sits directly downstream of the pipeline MEM stage and serves its D-side port: address, read/write, byte mask, write data, read data and response.
- Misses are filled from physical memory over a 128-bit line port.
- Hits complete in the same cycle the request is presented, so the MEM-stage stall clears without an extra cycle.

Parameters:
- NUM_SETS, 8: number of cache lines; power of two, minimum 2.
- LINE_BYTES, 16: bytes per line; fixed at 16 (offset = addr[3:0]).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- mem_address  in  16  CPU byte address; word select = addr[3:1]
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_byte_enable  in  2  byte mask: bit0 = low byte, bit1 = high byte
- mem_wdata  in  16  CPU write data
- mem_rdata  out  16  CPU read data (valid when mem_resp=1)
- mem_resp  out  1  CPU request done
- pmem_address  out  16  line-aligned physical address (bits [3:0] = 0)
- pmem_read  out  1  line fill request
- pmem_write  out  1  line writeback request
- pmem_wdata  out  128  victim line data
- pmem_rdata  in  128  fill data
- pmem_resp  in  1  physical memory done (one-cycle pulse)

Behaviour:
- Address split: offset[3:0]; index = addr[3+log2(NUM_SETS):4]; tag = remaining upper bits (9 bits at default).
- Per line: valid, dirty, tag, 128-bit data.
- Reset (asynchronous): all valid and dirty bits cleared; FSM goes to COMPARE.
- Reset values of outputs: mem_resp=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, mem_rdata=0.
- Tag and data arrays are not reset; they are never observable while invalid.
- FSM states: COMPARE, WRITEBACK, ALLOCATE.
- COMPARE with no request: idle; all outputs 0.
- COMPARE, request and hit (valid && tag match):
  - mem_resp=1 combinationally in the same cycle.
  - mem_rdata = selected 16-bit word.
  - A write updates only the enabled bytes at the clock edge and sets dirty if any enable bit is 1.
  - A write with byte_enable=00 acks with no state change.
- COMPARE, request and miss:
  - Go to WRITEBACK if the line is valid and dirty; otherwise go to ALLOCATE.
  - mem_resp=0.
- WRITEBACK:
  - pmem_write=1; pmem_address = {old tag, index, 4'b0}; pmem_wdata = line data.
  - On pmem_resp: clear dirty, go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1; pmem_address = {new tag, index, 4'b0}.
  - On pmem_resp: load data, tag, valid=1, dirty=0, return to COMPARE.
  - The next cycle is a hit, so miss latency = memory latency + 1 cycle.
- mem_read and mem_write both high: treated as a write.
- CPU request dropped mid-miss: the fill or writeback still completes; no mem_resp is issued.
- Address or data changing while the FSM is not in COMPARE: the fill uses the address latched on entry to the miss.
  - On return to COMPARE the current address is re-evaluated, and may miss again.
- pmem_read and pmem_write are never high together; both are 0 in COMPARE.
- Reset mid-miss: pmem_read and pmem_write drop immediately; a late pmem_resp is ignored.

Optional Feature:
- Macro: D_CACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count (16) and miss_count (16).
  - hit_count increments on each cycle with mem_resp=1.
  - miss_count increments once per COMPARE→WRITEBACK or COMPARE→ALLOCATE transition.
  - Both counters saturate at 16'hFFFF and are cleared by reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cache_types holds:
  - lc3b_c_line (128-bit line type)
  - default tag, index and offset width constants
  - FSM state enum d_cache_state_t (COMPARE, WRITEBACK, ALLOCATE)
- Sub-module d_cache_array holds the valid, dirty, tag and data storage.
  - Combinational read port.
  - One write port for line fill, byte-masked word write and dirty/valid update.
- The controller FSM remains in d_cache.

Test Plan:
- After reset, read 0x0010 with pmem latency 3:
  - ALLOCATE with pmem_address=0x0010; mem_resp on cycle 5.
  - mem_rdata = word 0 of the fill line.
- Read 0x0012 immediately after that fill → same-cycle mem_resp=1 with word 1 of the line; no pmem activity.
- Write 0xBEEF, byte_enable=01, to 0x0014, then read 0x0014 → 0x??EF, with the high byte unchanged from the fill.
  - Dirty bit is set.
- Read 0x0090, which has the same index as 0x0010 and a different tag:
  - pmem_write to 0x0010 carrying the modified line, then pmem_read of 0x0090, then a hit.
  - miss_count increments by 1 when D_CACHE_STATS_EN is defined.
- Drop mem_read mid-ALLOCATE → the fill completes, mem_resp stays 0, and a later read of that line hits in one cycle.
- Assert reset during WRITEBACK → pmem_write drops in the same cycle; a subsequent read of the same address misses because valid was cleared.

Source files
------------

// File: rtl/d_cache_pkg.sv
// Shared line type, default address-field widths and controller state encoding
// for the direct-mapped write-back data cache.
package cache_types;

   typedef logic [127:0] lc3b_c_line;

   localparam int OFFSET_W = 4;
   localparam int INDEX_W  = 3;
   localparam int TAG_W    = 9;

   localparam logic [1:0] ST_COMPARE   = 2'd0;
   localparam logic [1:0] ST_WRITEBACK = 2'd1;
   localparam logic [1:0] ST_ALLOCATE  = 2'd2;

   typedef enum logic [1:0] {
      COMPARE   = ST_COMPARE,
      WRITEBACK = ST_WRITEBACK,
      ALLOCATE  = ST_ALLOCATE
   } d_cache_state_t;

   // Picks 16-bit word sel (0..7) out of a 128-bit line.
   function automatic logic [15:0] line_word(input lc3b_c_line line, input logic [2:0] sel);
      return line[{sel, 4'd0} +: 16];
   endfunction

endpackage

// File: rtl/d_cache_if.sv
// CPU-side (MEM stage) and physical-memory-side signal bundle of the data cache.
// The slave modport is the cache's view; master is the surrounding system's view.
interface d_cache_if;
   import cache_types::*;

   logic [15:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_byte_enable;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_resp;

   logic [15:0] pmem_address;
   logic        pmem_read;
   logic        pmem_write;
   lc3b_c_line  pmem_wdata;
   lc3b_c_line  pmem_rdata;
   logic        pmem_resp;

   modport slave (
      input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
      output mem_rdata, mem_resp,
      output pmem_address, pmem_read, pmem_write, pmem_wdata,
      input  pmem_rdata, pmem_resp
   );

   modport master (
      output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
      input  mem_rdata, mem_resp,
      input  pmem_address, pmem_read, pmem_write, pmem_wdata,
      output pmem_rdata, pmem_resp
   );

endinterface

// File: rtl/d_cache_array.sv
// Valid/dirty/tag/data storage for the data cache: combinational read of one set,
// single write port for line fill, byte-masked word write and dirty clear.
module d_cache_array
   import cache_types::*;
#(
   parameter  int NUM_SETS = 8,
   localparam int IDX_W    = $clog2(NUM_SETS),
   localparam int TAG_BITS = 16 - OFFSET_W - IDX_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [IDX_W-1:0]    index,
   output logic                valid,
   output logic                dirty,
   output logic [TAG_BITS-1:0] tag,
   output lc3b_c_line          data,
   input  logic                fill,
   input  logic [TAG_BITS-1:0] fill_tag,
   input  lc3b_c_line          fill_data,
   input  logic                word_write,
   input  logic [2:0]          word_sel,
   input  logic [1:0]          byte_enable,
   input  logic [15:0]         wdata,
   input  logic                clean
);

   logic [NUM_SETS-1:0] valid_r;
   logic [NUM_SETS-1:0] dirty_r;
   logic [TAG_BITS-1:0] tag_r  [NUM_SETS];
   lc3b_c_line          data_r [NUM_SETS];

   assign valid = valid_r[index];
   assign dirty = dirty_r[index];
   assign tag   = tag_r[index];
   assign data  = data_r[index];

   // Line status bits; the only state that reset has to clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_r <= {NUM_SETS{1'b0}};
         dirty_r <= {NUM_SETS{1'b0}};
      end else if (fill) begin
         valid_r[index] <= 1'b1;
         dirty_r[index] <= 1'b0;
      end else if (clean) begin
         dirty_r[index] <= 1'b0;
      end else if (word_write && (byte_enable != 2'b00)) begin
         dirty_r[index] <= 1'b1;
      end
   end

   // Tag and data payload; unreset because nothing reads it while the line is invalid
   always_ff @(posedge clk) begin
      if (fill) begin
         tag_r[index]  <= fill_tag;
         data_r[index] <= fill_data;
      end else if (word_write) begin
         if (byte_enable[0]) data_r[index][{word_sel, 4'd0} +: 8] <= wdata[7:0];
         if (byte_enable[1]) data_r[index][{word_sel, 4'd8} +: 8] <= wdata[15:8];
      end
   end

endmodule

// File: rtl/d_cache.sv
// Direct-mapped, write-back, write-allocate data cache with same-cycle hit response.
// Optional hit/miss counters are enabled by defining D_CACHE_STATS_EN.
module d_cache
   import cache_types::*;
#(
   parameter int NUM_SETS = 8
) (
   input  logic        clk,
   input  logic        reset,
`ifdef D_CACHE_STATS_EN
   output logic [15:0] hit_count,
   output logic [15:0] miss_count,
`endif
   d_cache_if.slave    bus
);

   localparam int IDX_W    = $clog2(NUM_SETS);
   localparam int TAG_BITS = 16 - OFFSET_W - IDX_W;

   d_cache_state_t      state_r;
   d_cache_state_t      state_next;
   logic [IDX_W-1:0]    miss_index_r;
   logic [TAG_BITS-1:0] miss_tag_r;

   logic [IDX_W-1:0]    cur_index_s;
   logic [TAG_BITS-1:0] cur_tag_s;
   logic [IDX_W-1:0]    index_s;
   logic                req_s;
   logic                in_compare_s;
   logic                hit_s;
   logic                miss_s;
   logic                line_valid_s;
   logic                line_dirty_s;
   logic [TAG_BITS-1:0] line_tag_s;
   lc3b_c_line          line_data_s;
   logic                fill_s;
   logic                clean_s;
   logic [15:0]         rdata_s;
   logic                pmem_read_s;
   logic                pmem_write_s;
   logic [15:0]         pmem_addr_s;
   lc3b_c_line          pmem_wdata_s;
   logic                unused_addr_bit;

   assign cur_index_s  = bus.mem_address[OFFSET_W +: IDX_W];
   assign cur_tag_s    = bus.mem_address[15 -: TAG_BITS];
   assign req_s        = bus.mem_read | bus.mem_write;
   assign in_compare_s = (state_r == COMPARE);
   // Outside COMPARE the array follows the latched miss, not the live address
   assign index_s      = in_compare_s ? cur_index_s : miss_index_r;
   assign hit_s        = in_compare_s && req_s && line_valid_s && (line_tag_s == cur_tag_s);
   assign miss_s       = in_compare_s && req_s && !hit_s;
   assign unused_addr_bit = bus.mem_address[0];

   d_cache_array #(.NUM_SETS(NUM_SETS)) u_array (
      .clk         (clk),
      .reset       (reset),
      .index       (index_s),
      .valid       (line_valid_s),
      .dirty       (line_dirty_s),
      .tag         (line_tag_s),
      .data        (line_data_s),
      .fill        (fill_s),
      .fill_tag    (miss_tag_r),
      .fill_data   (bus.pmem_rdata),
      .word_write  (hit_s && bus.mem_write),
      .word_sel    (bus.mem_address[3:1]),
      .byte_enable (bus.mem_byte_enable),
      .wdata       (bus.mem_wdata),
      .clean       (clean_s)
   );

   // Controller outputs and next-state selection
   always_comb begin
      state_next   = state_r;
      rdata_s      = 16'h0000;
      pmem_read_s  = 1'b0;
      pmem_write_s = 1'b0;
      pmem_addr_s  = 16'h0000;
      pmem_wdata_s = {128{1'b0}};
      fill_s       = 1'b0;
      clean_s      = 1'b0;
      if (hit_s) begin
         rdata_s = line_word(line_data_s, bus.mem_address[3:1]);
      end else begin
         rdata_s = 16'h0000;
      end
      case (state_r)
         COMPARE: begin
            if (miss_s) begin
               if (line_valid_s && line_dirty_s) state_next = WRITEBACK;
               else                              state_next = ALLOCATE;
            end else begin
               state_next = COMPARE;
            end
         end
         WRITEBACK: begin
            pmem_write_s = 1'b1;
            pmem_addr_s  = {line_tag_s, miss_index_r, 4'h0};
            pmem_wdata_s = line_data_s;
            if (bus.pmem_resp) begin
               clean_s    = 1'b1;
               state_next = ALLOCATE;
            end else begin
               state_next = WRITEBACK;
            end
         end
         ALLOCATE: begin
            pmem_read_s = 1'b1;
            pmem_addr_s = {miss_tag_r, miss_index_r, 4'h0};
            if (bus.pmem_resp) begin
               fill_s     = 1'b1;
               state_next = COMPARE;
            end else begin
               state_next = ALLOCATE;
            end
         end
         default: state_next = COMPARE;
      endcase
   end

   // FSM state and the address captured when a miss is taken
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= COMPARE;
         miss_tag_r   <= {TAG_BITS{1'b0}};
         miss_index_r <= {IDX_W{1'b0}};
      end else begin
         state_r <= state_next;
         if (miss_s) begin
            miss_tag_r   <= cur_tag_s;
            miss_index_r <= cur_index_s;
         end
      end
   end

   assign bus.mem_resp     = hit_s;
   assign bus.mem_rdata    = rdata_s;
   assign bus.pmem_read    = pmem_read_s;
   assign bus.pmem_write   = pmem_write_s;
   assign bus.pmem_address = pmem_addr_s;
   assign bus.pmem_wdata   = pmem_wdata_s;

`ifdef D_CACHE_STATS_EN
   logic [15:0] hit_count_r;
   logic [15:0] miss_count_r;

   // Saturating hit/miss event counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_count_r  <= 16'h0000;
         miss_count_r <= 16'h0000;
      end else begin
         if (hit_s && (hit_count_r != 16'hFFFF))   hit_count_r  <= hit_count_r + 16'd1;
         if (miss_s && (miss_count_r != 16'hFFFF)) miss_count_r <= miss_count_r + 16'd1;
      end
   end

   assign hit_count  = hit_count_r;
   assign miss_count = miss_count_r;
`endif

endmodule

// File: tb/tb_d_cache.sv
// Self-checking bench for d_cache: directed scenarios plus randomized accesses
// checked against a flat memory view and a per-set residency model.
`timescale 1ns/1ps
module tb_d_cache;
   import cache_types::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   d_cache_if bus();
`ifdef D_CACHE_STATS_EN
   logic [15:0] hit_count;
   logic [15:0] miss_count;
`endif

   d_cache #(.NUM_SETS(8)) dut (
      .clk        (clk),
      .reset      (reset),
`ifdef D_CACHE_STATS_EN
      .hit_count  (hit_count),
      .miss_count (miss_count),
`endif
      .bus        (bus)
   );

   int checks = 0;
   int errors = 0;
   int lat    = 3;
   int busy   = 0;
   int exp_hits   = 0;
   int exp_misses = 0;

   lc3b_c_line pmem  [logic [11:0]];
   lc3b_c_line cview [logic [11:0]];
   logic       res_valid [8];
   logic       res_dirty [8];
   logic [8:0] res_tag   [8];

   function automatic lc3b_c_line init_line(input logic [11:0] la);
      lc3b_c_line l;
      for (int w = 0; w < 8; w++) l[w*16 +: 16] = 16'({la, 4'(w)} * 40503) ^ 16'hC3A5;
      return l;
   endfunction

   function automatic lc3b_c_line get_p(input logic [11:0] la);
      if (pmem.exists(la)) return pmem[la];
      return init_line(la);
   endfunction

   function automatic lc3b_c_line get_c(input logic [11:0] la);
      if (cview.exists(la)) return cview[la];
      return get_p(la);
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 8; i++) begin
         res_valid[i] = 1'b0;
         res_dirty[i] = 1'b0;
         res_tag[i]   = 9'd0;
      end
      cview.delete();
      busy = 0;
      exp_hits = 0;
      exp_misses = 0;
   endtask

   // One clock cycle: physical memory model, then sample CPU-side outputs.
   task automatic step(output logic resp, output logic [15:0] rdata,
                       output logic pr, output logic pw, output logic [15:0] pa);
      bus.pmem_resp = 1'b0;
      pr = bus.pmem_read;
      pw = bus.pmem_write;
      pa = bus.pmem_address;
      if (pr || pw) begin
         checks++;
         if (pr && pw) begin
            errors++;
            $display("FAIL pmem_exclusive read=%b write=%b required not both", pr, pw);
         end
         checks++;
         if (pa[3:0] !== 4'h0) begin
            errors++;
            $display("FAIL pmem_align address=%h required low nibble 0", pa);
         end
         busy++;
         if (busy >= lat) begin
            busy = 0;
            bus.pmem_resp = 1'b1;
            if (pw) begin
               checks++;
               if (bus.pmem_wdata !== get_c(pa[15:4])) begin
                  errors++;
                  $display("FAIL wb_data addr=%h got=%h expected=%h", pa, bus.pmem_wdata, get_c(pa[15:4]));
               end
               pmem[pa[15:4]] = bus.pmem_wdata;
            end else begin
               bus.pmem_rdata = get_p(pa[15:4]);
            end
         end
      end else begin
         busy = 0;
      end
      #2;
      resp  = bus.mem_resp;
      rdata = bus.mem_rdata;
      @(posedge clk);
      #1;
   endtask

   // Full CPU transaction held until mem_resp, checked against the model.
   task automatic do_access(input logic rd, input logic wr, input logic [15:0] addr,
                            input logic [1:0] be, input logic [15:0] wd, output logic [15:0] got);
      logic [11:0] la;
      logic [2:0]  ix;
      logic [8:0]  tg;
      logic [15:0] victim, exp_word, rdata, pa;
      logic        resp, pr, pw;
      bit          is_hit, dirty_miss, saw_rd, saw_wr;
      int          exp_cyc, n;
      lc3b_c_line  l;
      la = addr[15:4];
      ix = addr[6:4];
      tg = addr[15:7];
      is_hit     = res_valid[ix] && (res_tag[ix] == tg);
      dirty_miss = !is_hit && res_valid[ix] && res_dirty[ix];
      victim     = {res_tag[ix], ix, 4'h0};
      exp_cyc    = is_hit ? 1 : (dirty_miss ? 2*lat + 2 : lat + 2);
      l = get_c(la);
      exp_word = l[addr[3:1]*16 +: 16];
      saw_rd = 0; saw_wr = 0; n = 0; resp = 1'b0; rdata = 16'h0;
      bus.mem_read = rd;
      bus.mem_write = wr;
      bus.mem_address = addr;
      bus.mem_byte_enable = be;
      bus.mem_wdata = wd;
      while (!resp && n < 40) begin
         step(resp, rdata, pr, pw, pa);
         n++;
         if (pw && !saw_wr) begin
            saw_wr = 1;
            checks++;
            if (pa !== victim) begin
               errors++;
               $display("FAIL wb_addr got=%h expected=%h", pa, victim);
            end
         end
         if (pr && !saw_rd) begin
            saw_rd = 1;
            checks++;
            if (pa !== {la, 4'h0}) begin
               errors++;
               $display("FAIL fill_addr got=%h expected=%h", pa, {la, 4'h0});
            end
         end
      end
      checks++;
      if (!resp || n != exp_cyc) begin
         errors++;
         $display("FAIL latency addr=%h cycles=%0d resp=%b expected=%0d", addr, n, resp, exp_cyc);
      end
      checks++;
      if (saw_wr != dirty_miss) begin
         errors++;
         $display("FAIL writeback_seen addr=%h got=%0d expected=%0d", addr, saw_wr, dirty_miss);
      end
      checks++;
      if (saw_rd != !is_hit) begin
         errors++;
         $display("FAIL fill_seen addr=%h got=%0d expected=%0d", addr, saw_rd, !is_hit);
      end
      checks++;
      if (rdata !== exp_word) begin
         errors++;
         $display("FAIL rdata addr=%h got=%h expected=%h", addr, rdata, exp_word);
      end
      if (!is_hit) begin
         res_valid[ix] = 1'b1;
         res_tag[ix]   = tg;
         res_dirty[ix] = 1'b0;
         exp_misses++;
      end
      exp_hits++;
      if (wr && be != 2'b00) begin
         if (be[0]) l[addr[3:1]*16 +: 8]     = wd[7:0];
         if (be[1]) l[addr[3:1]*16 + 8 +: 8] = wd[15:8];
         cview[la] = l;
         res_dirty[ix] = 1'b1;
      end
      bus.mem_read = 1'b0;
      bus.mem_write = 1'b0;
      got = rdata;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.mem_read = 1'b0;
      bus.mem_write = 1'b0;
      bus.mem_address = 16'h0000;
      bus.mem_byte_enable = 2'b00;
      bus.mem_wdata = 16'h0000;
      bus.pmem_resp = 1'b0;
      bus.pmem_rdata = {128{1'b0}};
      clear_model();
      repeat (2) @(posedge clk);
      #3;
      checks++;
      if (bus.mem_resp !== 1'b0 || bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl resp=%b pread=%b pwrite=%b expected 0 0 0",
                  bus.mem_resp, bus.pmem_read, bus.pmem_write);
      end
      checks++;
      if (bus.pmem_address !== 16'h0000 || bus.pmem_wdata !== {128{1'b0}} || bus.mem_rdata !== 16'h0000) begin
         errors++;
         $display("FAIL reset_data paddr=%h pwdata=%h rdata=%h expected zeros",
                  bus.pmem_address, bus.pmem_wdata, bus.mem_rdata);
      end
`ifdef D_CACHE_STATS_EN
      checks++;
      if (hit_count !== 16'h0 || miss_count !== 16'h0) begin
         errors++;
         $display("FAIL reset_stats hits=%0d misses=%0d expected 0 0", hit_count, miss_count);
      end
`endif
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_directed();
      logic [15:0] got;
      lc3b_c_line  l;
      lat = 3;
      l = init_line(12'h001);
      do_access(1'b1, 1'b0, 16'h0010, 2'b11, 16'h0000, got);
      checks++;
      if (got !== l[15:0]) begin
         errors++;
         $display("FAIL first_fill_word0 got=%h expected=%h", got, l[15:0]);
      end
      do_access(1'b1, 1'b0, 16'h0012, 2'b11, 16'h0000, got);
      checks++;
      if (got !== l[31:16]) begin
         errors++;
         $display("FAIL hit_word1 got=%h expected=%h", got, l[31:16]);
      end
      do_access(1'b0, 1'b1, 16'h0014, 2'b01, 16'hBEEF, got);
      do_access(1'b1, 1'b0, 16'h0014, 2'b11, 16'h0000, got);
      checks++;
      if (got !== {l[47:40], 8'hEF}) begin
         errors++;
         $display("FAIL byte_write got=%h expected=%h", got, {l[47:40], 8'hEF});
      end
      do_access(1'b1, 1'b0, 16'h0090, 2'b11, 16'h0000, got);
`ifdef D_CACHE_STATS_EN
      checks++;
      if (miss_count !== 16'(exp_misses) || hit_count !== 16'(exp_hits)) begin
         errors++;
         $display("FAIL stats_directed hits=%0d misses=%0d expected %0d %0d",
                  hit_count, miss_count, exp_hits, exp_misses);
      end
`endif
      for (int w = 0; w < 8; w++) do_access(1'b1, 1'b0, 16'(16'h0090 + 2*w), 2'b11, 16'h0000, got);
   endtask

   task automatic test_drop();
      logic        resp, pr, pw;
      logic [15:0] rd, pa, got;
      int          any_resp = 0;
      int          fills = 0;
      lc3b_c_line  l;
      lat = 3;
      bus.mem_address = 16'h0120;
      bus.mem_byte_enable = 2'b11;
      bus.mem_write = 1'b0;
      bus.mem_read = 1'b1;
      step(resp, rd, pr, pw, pa);
      if (resp) any_resp++;
      step(resp, rd, pr, pw, pa);
      if (pr) fills++;
      if (resp) any_resp++;
      bus.mem_read = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(resp, rd, pr, pw, pa);
         if (pr) fills++;
         if (resp) any_resp++;
      end
      checks++;
      if (any_resp != 0) begin
         errors++;
         $display("FAIL drop_resp got=%0d responses expected=0", any_resp);
      end
      checks++;
      if (fills != lat) begin
         errors++;
         $display("FAIL drop_fill_cycles got=%0d expected=%0d", fills, lat);
      end
      res_valid[2] = 1'b1;
      res_tag[2]   = 9'd2;
      res_dirty[2] = 1'b0;
      exp_misses++;
      do_access(1'b1, 1'b0, 16'h0120, 2'b11, 16'h0000, got);
      l = get_p(12'h012);
      checks++;
      if (got !== l[15:0]) begin
         errors++;
         $display("FAIL drop_then_hit got=%h expected=%h", got, l[15:0]);
      end
   endtask

   task automatic test_reset_mid_writeback();
      logic        resp, pr, pw;
      logic [15:0] rd, pa, got;
      lc3b_c_line  l;
      lat = 2;
      do_access(1'b0, 1'b1, 16'h0220, 2'b11, 16'h1234, got);
      bus.mem_address = 16'h0320;
      bus.mem_read = 1'b1;
      step(resp, rd, pr, pw, pa);
      checks++;
      if (bus.pmem_write !== 1'b1) begin
         errors++;
         $display("FAIL wb_started got=%b expected=1", bus.pmem_write);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (bus.pmem_write !== 1'b0 || bus.pmem_read !== 1'b0 || bus.mem_resp !== 1'b0) begin
         errors++;
         $display("FAIL reset_drop pwrite=%b pread=%b resp=%b expected 0 0 0",
                  bus.pmem_write, bus.pmem_read, bus.mem_resp);
      end
      bus.mem_read = 1'b0;
      bus.pmem_resp = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      bus.pmem_resp = 1'b0;
      clear_model();
      checks++;
      if (bus.pmem_write !== 1'b0 || bus.pmem_read !== 1'b0) begin
         errors++;
         $display("FAIL late_resp pwrite=%b pread=%b expected 0 0", bus.pmem_write, bus.pmem_read);
      end
      do_access(1'b1, 1'b0, 16'h0220, 2'b11, 16'h0000, got);
      l = init_line(12'h022);
      checks++;
      if (got !== l[15:0]) begin
         errors++;
         $display("FAIL lost_dirty_data got=%h expected=%h", got, l[15:0]);
      end
   endtask

   task automatic test_random();
      logic [8:0]  tg;
      logic [2:0]  ix;
      logic [3:0]  off;
      logic [1:0]  be;
      logic [15:0] got;
      int          op;
      for (int i = 0; i < 300; i++) begin
         lat = $urandom_range(1, 4);
         tg  = 9'($urandom_range(0, 3));
         ix  = 3'($urandom_range(0, 7));
         off = 4'($urandom_range(0, 15));
         be  = 2'($urandom_range(0, 3));
         op  = $urandom_range(0, 3);
         do_access(op != 2, op >= 2, {tg, ix, off}, be, 16'($urandom), got);
      end
`ifdef D_CACHE_STATS_EN
      checks++;
      if (hit_count !== 16'(exp_hits) || miss_count !== 16'(exp_misses)) begin
         errors++;
         $display("FAIL stats_random hits=%0d misses=%0d expected %0d %0d",
                  hit_count, miss_count, exp_hits, exp_misses);
      end
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_drop();
      test_reset_mid_writeback();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
